// File: rtl/axi4_ram_bridge.sv
// AXI4 slave bridging burst transactions onto a word-indexed RAM helper port.
// One transaction at a time; alternating grant when reads and writes collide.
module axi4_ram_bridge #(
  parameter logic [63:0] MEM_BASE = 64'h8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h8000_0000,
  parameter int unsigned ID_W     = 4
) (
  input  logic            clock,
  input  logic            reset,

  input  logic            aw_valid,
  output logic            aw_ready,
  input  logic [63:0]     aw_addr,
  input  logic [ID_W-1:0] aw_id,
  input  logic [7:0]      aw_len,
  input  logic [2:0]      aw_size,
  input  logic [1:0]      aw_burst,

  input  logic            w_valid,
  output logic            w_ready,
  input  logic [63:0]     w_data,
  input  logic [7:0]      w_strb,
  input  logic            w_last,

  output logic            b_valid,
  input  logic            b_ready,
  output logic [ID_W-1:0] b_id,
  output logic [1:0]      b_resp,

  input  logic            ar_valid,
  output logic            ar_ready,
  input  logic [63:0]     ar_addr,
  input  logic [ID_W-1:0] ar_id,
  input  logic [7:0]      ar_len,
  input  logic [2:0]      ar_size,
  input  logic [1:0]      ar_burst,

  output logic            r_valid,
  input  logic            r_ready,
  output logic [63:0]     r_data,
  output logic [ID_W-1:0] r_id,
  output logic [1:0]      r_resp,
  output logic            r_last,

  output logic [63:0]     ram_rIdx,
  input  logic [63:0]     ram_rdata,
  output logic [63:0]     ram_wIdx,
  output logic [63:0]     ram_wdata,
  output logic [63:0]     ram_wmask,
  output logic            ram_wen
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef enum logic [1:0] {StIdle, StRd, StWrData, StWrResp} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [7:0]      len_q, len_d;
  logic [1:0]      burst_q, burst_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [63:0]     idx_q, idx_d;
  logic            err_q, err_d;
  logic            slverr_q, slverr_d;
  logic            last_wr_q, last_wr_d;

  logic            grant_rd, grant_wr;
  logic [63:0]     sel_addr, sel_off;
  logic            sel_err;

  // Transfer size is fixed at one 64-bit word per beat.
  logic unused_size;
  assign unused_size = ^{ar_size, aw_size};

  function automatic logic [63:0] next_idx(input logic [63:0] idx, input logic [1:0] burst,
                                           input logic [7:0] len);
    logic [63:0] len_w;
    len_w = {56'd0, len};
    case (burst)
      2'b00:   return idx;
      2'b10:   return (idx & ~len_w) | ((idx + 64'd1) & len_w);
      default: return idx + 64'd1;
    endcase
  endfunction

  // Read wins a collision unless it also won the previous one.
  assign grant_rd = ar_valid && (!aw_valid || last_wr_q);
  assign grant_wr = aw_valid && (!ar_valid || !last_wr_q);

  assign sel_addr = grant_rd ? ar_addr : aw_addr;
  assign sel_off  = sel_addr - MEM_BASE;
  assign sel_err  = (sel_addr < MEM_BASE) || (sel_off >= MEM_SIZE);

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    slverr_d  = slverr_q;
    last_wr_d = last_wr_q;

    ar_ready  = 1'b0;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    b_id      = '0;
    b_resp    = RespOkay;
    r_valid   = 1'b0;
    r_data    = '0;
    r_id      = '0;
    r_resp    = RespOkay;
    r_last    = 1'b0;
    ram_rIdx  = '0;
    ram_wIdx  = '0;
    ram_wen   = 1'b0;
    ram_wdata = w_data;
    ram_wmask = '0;
    for (int k = 0; k < 8; k++) begin
      ram_wmask[8*k +: 8] = {8{w_strb[k]}};
    end

    case (state_q)
      StIdle: begin
        ar_ready = grant_rd;
        aw_ready = grant_wr;
        if (grant_rd || grant_wr) begin
          id_d      = grant_rd ? ar_id : aw_id;
          len_d     = grant_rd ? ar_len : aw_len;
          cnt_d     = grant_rd ? ar_len : aw_len;
          burst_d   = grant_rd ? ar_burst : aw_burst;
          idx_d     = sel_off >> 3;
          err_d     = sel_err;
          last_wr_d = grant_wr;
          state_d   = grant_rd ? StRd : StWrData;
        end
      end
      StRd: begin
        r_valid  = 1'b1;
        ram_rIdx = idx_q;
        r_data   = err_q ? '0 : ram_rdata;
        r_resp   = err_q ? RespDecerr : RespOkay;
        r_id     = id_q;
        r_last   = (cnt_q == 8'd0);
        if (r_ready) begin
          if (cnt_q == 8'd0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 8'd1;
            idx_d = next_idx(idx_q, burst_q, len_q);
          end
        end
      end
      StWrData: begin
        w_ready  = 1'b1;
        ram_wIdx = idx_q;
        ram_wen  = w_valid && !err_q;
        if (w_valid) begin
          if (w_last != (cnt_q == 8'd0)) slverr_d = 1'b1;
          cnt_d = cnt_q - 8'd1;
          idx_d = next_idx(idx_q, burst_q, len_q);
          // Beat count, not w_last, terminates the burst.
          if (cnt_q == 8'd0) state_d = StWrResp;
        end
      end
      StWrResp: begin
        b_valid = 1'b1;
        b_id    = id_q;
        b_resp  = err_q ? RespDecerr : (slverr_q ? RespSlverr : RespOkay);
        if (b_ready) begin
          state_d  = StIdle;
          slverr_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Quiesce every handshake and RAM strobe while reset is held.
    if (reset) begin
      ar_ready = 1'b0;
      aw_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      b_id     = '0;
      b_resp   = RespOkay;
      r_valid  = 1'b0;
      r_data   = '0;
      r_id     = '0;
      r_resp   = RespOkay;
      r_last   = 1'b0;
      ram_rIdx = '0;
      ram_wIdx = '0;
      ram_wen  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      id_q      <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      err_q     <= 1'b0;
      slverr_q  <= 1'b0;
      last_wr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      slverr_q  <= slverr_d;
      last_wr_q <= last_wr_d;
    end
  end

endmodule

// File: tb/tb_axi4_ram_bridge.sv
// Scoreboard bench for axi4_ram_bridge with a behavioural RAM helper.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_axi4_ram_bridge;

  localparam logic [63:0] Base = 64'h8000_0000;
  localparam logic [63:0] Size = 64'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        aw_valid = 0, aw_ready;
  logic [63:0] aw_addr = 0;
  logic [3:0]  aw_id = 0;
  logic [7:0]  aw_len = 0;
  logic [2:0]  aw_size = 3'd3;
  logic [1:0]  aw_burst = 0;
  logic        w_valid = 0, w_ready;
  logic [63:0] w_data = 0;
  logic [7:0]  w_strb = 0;
  logic        w_last = 0;
  logic        b_valid, b_ready = 0;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        ar_valid = 0, ar_ready;
  logic [63:0] ar_addr = 0;
  logic [3:0]  ar_id = 0;
  logic [7:0]  ar_len = 0;
  logic [2:0]  ar_size = 3'd3;
  logic [1:0]  ar_burst = 0;
  logic        r_valid, r_ready = 0;
  logic [63:0] r_data;
  logic [3:0]  r_id;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [63:0] ram_rIdx, ram_rdata, ram_wIdx, ram_wdata, ram_wmask;
  logic        ram_wen;

  int n_checks = 0;
  int n_errors = 0;

  axi4_ram_bridge #(.MEM_BASE(Base), .MEM_SIZE(Size), .ID_W(4)) dut (
    .clock(clock), .reset(reset),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_id(aw_id),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_id(r_id), .r_resp(r_resp),
    .r_last(r_last),
    .ram_rIdx(ram_rIdx), .ram_rdata(ram_rdata), .ram_wIdx(ram_wIdx), .ram_wdata(ram_wdata),
    .ram_wmask(ram_wmask), .ram_wen(ram_wen)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] pat(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'h1234_0000 + 32'(i)};
  endfunction

  // RAM helper: combinational read, write on the rising edge when enabled.
  logic [63:0] mem [64];
  bit          init_done = 0;
  always @(posedge clock) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
      init_done <= 1'b1;
    end else if (ram_wen) begin
      mem[ram_wIdx[5:0]] <= (mem[ram_wIdx[5:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end
  end
  assign ram_rdata = mem[ram_rIdx[5:0]];

  logic [63:0] exp_mem [64];

  typedef struct { logic [63:0] data; logic [63:0] idx; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [63:0] data; logic [63:0] idx; logic [63:0] mask; logic wen; } wbeat_t;
  rbeat_t r_q[$];
  wbeat_t w_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_next(input logic [63:0] idx, input logic [1:0] burst,
                                             input int len);
    logic [63:0] sz, base;
    if (burst == 2'b00) return idx;
    if (burst == 2'b10) begin
      sz   = 64'(len + 1);
      base = (idx / sz) * sz;
      return base + ((idx - base + 64'd1) % sz);
    end
    return idx + 64'd1;
  endfunction

  function automatic logic [63:0] mask_of(input logic [7:0] strb);
    logic [63:0] m;
    for (int k = 0; k < 8; k++) m[8*k +: 8] = strb[k] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic logic [7:0] strb_of(input logic [31:0] strb_pat, input int b);
    if (b < 4) return strb_pat[8*b +: 8];
    return 8'hFF;
  endfunction

  function automatic bit out_of_range(input logic [63:0] addr);
    return (addr < Base) || (addr >= Base + Size);
  endfunction

  task automatic do_ar(input logic [63:0] addr, input int len, input logic [1:0] burst,
                       input logic [3:0] id, input logic [7:0] rpat);
    logic [63:0] idx;
    bit          err, ok;
    int          cyc;
    idx = (addr - Base) >> 3;
    err = out_of_range(addr);
    for (int b = 0; b <= len; b++) begin
      r_q.push_back('{data: err ? 64'd0 : exp_mem[idx[5:0]], idx: idx,
                      resp: err ? 2'b11 : 2'b00, last: (b == len)});
      idx = model_next(idx, burst, len);
    end
    @(negedge clock);
    ar_valid = 1; ar_addr = addr; ar_len = 8'(len); ar_burst = burst; ar_id = id;
    #1;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      if (ar_ready) begin ok = 1; break; end
      @(negedge clock); #1;
    end
    check("ar_handshake", 64'(ok), 64'd1);
    @(negedge clock);
    ar_valid = 0; cyc = 0; r_ready = rpat[0];
    #1;
    check("r_valid_first", 64'(r_valid), 64'd1);
    for (int c = 0; c < 64 && r_q.size() > 0; c++) begin
      check("r_valid", 64'(r_valid), 64'd1);
      if (r_valid) begin
        check("r_data", r_data, r_q[0].data);
        check("r_resp", 64'(r_resp), 64'(r_q[0].resp));
        check("r_last", 64'(r_last), 64'(r_q[0].last));
        check("r_id", 64'(r_id), 64'(id));
        check("ram_rIdx", ram_rIdx, r_q[0].idx);
        if (r_ready) void'(r_q.pop_front());
      end
      @(negedge clock);
      cyc++;
      r_ready = rpat[cyc % 8];
      #1;
    end
    check("r_beats_left", 64'(r_q.size()), 64'd0);
    r_q.delete();
    check("r_valid_done", 64'(r_valid), 64'd0);
    r_ready = 0;
  endtask

  task automatic do_aw(input logic [63:0] addr, input int len, input logic [1:0] burst,
                       input logic [3:0] id, input logic [63:0] seed,
                       input logic [31:0] strb_pat, input logic [15:0] wlast_pat);
    logic [63:0] idx, m, d;
    logic [1:0]  bresp;
    bit          err, slv, ok;
    int          b;
    idx = (addr - Base) >> 3;
    err = out_of_range(addr);
    slv = 0;
    for (int i = 0; i <= len; i++) begin
      m = mask_of(strb_of(strb_pat, i));
      d = seed + 64'(i);
      w_q.push_back('{data: d, idx: idx, mask: m, wen: !err});
      if (!err) exp_mem[idx[5:0]] = (exp_mem[idx[5:0]] & ~m) | (d & m);
      if (wlast_pat[i] != (i == len)) slv = 1;
      idx = model_next(idx, burst, len);
    end
    bresp = err ? 2'b11 : (slv ? 2'b10 : 2'b00);
    @(negedge clock);
    aw_valid = 1; aw_addr = addr; aw_len = 8'(len); aw_burst = burst; aw_id = id;
    #1;
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      if (aw_ready) begin ok = 1; break; end
      @(negedge clock); #1;
    end
    check("aw_handshake", 64'(ok), 64'd1);
    @(negedge clock);
    b = 0;
    aw_valid = 0; w_valid = 1; w_data = seed; w_strb = strb_of(strb_pat, 0);
    w_last = wlast_pat[0];
    #1;
    for (int c = 0; c < 64 && w_q.size() > 0; c++) begin
      check("w_ready", 64'(w_ready), 64'd1);
      check("ram_wen", 64'(ram_wen), 64'(w_q[0].wen));
      check("ram_wIdx", ram_wIdx, w_q[0].idx);
      check("ram_wmask", ram_wmask, w_q[0].mask);
      check("ram_wdata", ram_wdata, w_q[0].data);
      check("b_valid_early", 64'(b_valid), 64'd0);
      void'(w_q.pop_front());
      b++;
      @(negedge clock);
      if (w_q.size() > 0) begin
        w_data = seed + 64'(b); w_strb = strb_of(strb_pat, b); w_last = wlast_pat[b];
      end else begin
        w_valid = 0; w_last = 0;
      end
      #1;
    end
    check("w_beats_left", 64'(w_q.size()), 64'd0);
    w_q.delete();
    check("w_ready_resp", 64'(w_ready), 64'd0);
    check("b_valid", 64'(b_valid), 64'd1);
    check("b_resp", 64'(b_resp), 64'(bresp));
    check("b_id", 64'(b_id), 64'(id));
    @(negedge clock);
    b_ready = 1;
    #1;
    @(negedge clock);
    b_ready = 0;
    #1;
    check("b_valid_done", 64'(b_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    for (int i = 0; i < 64; i++) exp_mem[i] = pat(i);

    // Reset state, with both address channels requesting.
    ar_valid = 1; aw_valid = 1;
    ar_addr = Base; aw_addr = Base;
    repeat (3) @(negedge clock);
    #1;
    check("rst_ar_ready", 64'(ar_ready), 64'd0);
    check("rst_aw_ready", 64'(aw_ready), 64'd0);
    check("rst_r_valid", 64'(r_valid), 64'd0);
    check("rst_w_ready", 64'(w_ready), 64'd0);
    check("rst_b_valid", 64'(b_valid), 64'd0);
    check("rst_ram_wen", 64'(ram_wen), 64'd0);
    check("rst_ram_rIdx", ram_rIdx, 64'd0);
    check("rst_ram_wIdx", ram_wIdx, 64'd0);
    check("rst_r_last", 64'(r_last), 64'd0);
    check("rst_resps", 64'({r_resp, b_resp}), 64'd0);
    check("rst_ids", 64'({r_id, b_id}), 64'd0);
    @(negedge clock);
    reset = 0; ar_valid = 0; aw_valid = 0;

    // W beat offered in IDLE is not taken.
    @(negedge clock);
    w_valid = 1; w_strb = 8'hFF; w_last = 1;
    #1;
    check("idle_w_ready", 64'(w_ready), 64'd0);
    check("idle_ram_wen", 64'(ram_wen), 64'd0);
    @(negedge clock);
    w_valid = 0; w_last = 0;

    do_aw(64'h8000_0010, 0, 2'b01, 4'd3, 64'hDEAD_BEEF_0123_4567, 32'hFFFF_FFFF, 16'h0001);
    do_ar(64'h8000_0010, 0, 2'b01, 4'd5, 8'hFF);
    do_ar(64'h8000_0000, 3, 2'b01, 4'd1, 8'b0101_0101);
    do_aw(64'h8000_0030, 3, 2'b10, 4'd6, 64'h1111_2222_3333_0000, 32'hFF0F_FFFF, 16'h0008);
    do_ar(64'h8000_0030, 3, 2'b10, 4'd6, 8'hFF);
    do_ar(64'h0000_1000, 1, 2'b01, 4'd2, 8'hFF);
    do_aw(64'h0000_1000, 1, 2'b01, 4'd4, 64'h5555_0000_0000_0000, 32'hFFFF_FFFF, 16'h0002);
    do_aw(64'h8000_0100, 1, 2'b01, 4'd7, 64'h7777_8888_9999_0000, 32'h0000_00FF, 16'h0003);
    do_ar(64'h8000_0100, 1, 2'b01, 4'd7, 8'hFF);
    do_ar(64'h8000_0008, 2, 2'b00, 4'd8, 8'b1011_0110);
    do_ar(64'h8000_0040, 2, 2'b11, 4'd9, 8'hFF);

    // Reset during a read burst.
    @(negedge clock);
    ar_valid = 1; ar_addr = Base; ar_len = 8'd3; ar_burst = 2'b01; ar_id = 4'd1;
    #1;
    check("mid_ar_ready", 64'(ar_ready), 64'd1);
    @(negedge clock);
    ar_valid = 0; r_ready = 1;
    #1;
    check("mid_r_valid", 64'(r_valid), 64'd1);
    check("mid_r_data", r_data, exp_mem[0]);
    @(negedge clock);
    #1;
    check("mid_ram_rIdx", ram_rIdx, 64'd1);
    @(negedge clock);
    reset = 1;
    #1;
    check("mid_rst_r_valid", 64'(r_valid), 64'd0);
    @(negedge clock);
    reset = 0;
    #1;
    check("post_rst_r_valid", 64'(r_valid), 64'd0);
    check("post_rst_rIdx", ram_rIdx, 64'd0);
    @(negedge clock);
    r_ready = 0;
    #1;
    check("post_rst_idle", 64'(r_valid), 64'd0);

    // Collision twice in a row: read first, then write.
    @(negedge clock);
    ar_valid = 1; ar_addr = 64'h8000_0018; ar_len = 0; ar_burst = 2'b01; ar_id = 4'd9;
    aw_valid = 1; aw_addr = 64'h8000_0020; aw_len = 0; aw_burst = 2'b01; aw_id = 4'hA;
    #1;
    check("arb1_ar_ready", 64'(ar_ready), 64'd1);
    check("arb1_aw_ready", 64'(aw_ready), 64'd0);
    @(negedge clock);
    ar_valid = 0; r_ready = 1;
    #1;
    check("arb1_r_valid", 64'(r_valid), 64'd1);
    check("arb1_r_data", r_data, exp_mem[3]);
    check("arb1_r_last", 64'(r_last), 64'd1);
    check("arb1_r_id", 64'(r_id), 64'h9);
    check("arb1_aw_busy", 64'(aw_ready), 64'd0);
    @(negedge clock);
    ar_valid = 1; r_ready = 0;
    #1;
    check("arb2_aw_ready", 64'(aw_ready), 64'd1);
    check("arb2_ar_ready", 64'(ar_ready), 64'd0);
    @(negedge clock);
    d = 64'hCAFE_F00D_0000_0004;
    aw_valid = 0; ar_valid = 0;
    w_valid = 1; w_data = d; w_strb = 8'hFF; w_last = 1;
    exp_mem[4] = d;
    #1;
    check("arb2_ram_wen", 64'(ram_wen), 64'd1);
    check("arb2_ram_wIdx", ram_wIdx, 64'd4);
    @(negedge clock);
    w_valid = 0; w_last = 0; b_ready = 1;
    #1;
    check("arb2_b_valid", 64'(b_valid), 64'd1);
    check("arb2_b_resp", 64'(b_resp), 64'd0);
    check("arb2_b_id", 64'(b_id), 64'hA);
    @(negedge clock);
    b_ready = 0;
    #1;
    check("arb2_b_done", 64'(b_valid), 64'd0);
    do_ar(64'h8000_0020, 1, 2'b01, 4'd3, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
